// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU/MDU.
//   alu_op_e    - 5-bit operation encoding presented on alu_op
//   alu_state_e - sequencing state of alu_mdu (IDLE, MUL, DIV)
//   is_mul_op / is_div_op - classify an opcode as an iterative M-extension op
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_PASS   = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_e;

    function automatic logic is_mul_op(input alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bus between the execute stage and alu_mdu.
//   valid_i/ready_o  - request handshake (transfer on valid_i && ready_o)
//   alu_op, rs1, rs2 - operation and operands
//   valid_o, rd      - one-cycle result pulse and held result
// master: pipeline side; slave: alu_mdu side.
interface alu_mdu_if
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            valid_i;
    logic            ready_o;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            valid_o;
    logic [XLEN-1:0] rd;

    modport master (
        output valid_i, alu_op, rs1, rs2,
        input  ready_o, valid_o, rd
    );

    modport slave (
        input  valid_i, alu_op, rs1, rs2,
        output ready_o, valid_o, rd
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: shared iteration engine for unsigned multiply and divide.
//   clk, rst - clock, synchronous active-high reset
//   start    - latch a, b and begin XLEN iterations
//   abort    - drop the in-flight operation (wins over start)
//   is_div   - 1: restoring divide a / b, 0: add-shift multiply a * b
//   a, b     - unsigned operands (magnitudes)
//   done     - high in the cycle of the last iteration
//   result   - value after the current iteration; valid when done:
//              multiply {hi, lo} product, divide {remainder, quotient}
module mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN);

    logic              busy;
    logic              div_q;
    logic [CW-1:0]     cnt;
    // acc upper half: partial product / partial remainder;
    // acc lower half: multiplier bits / dividend bits shifting into quotient.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;

    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = shifted - {1'b0, opb};
        acc_step = '0;
        if (div_q) begin
            // partial remainder stays below the divisor, so diff[XLEN] is its sign
            if (diff[XLEN])
                acc_step = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {sum, acc[XLEN-1:1]};
        end
    end

    assign done   = busy && (cnt == CW'(XLEN - 1));
    assign result = acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            opb   <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            cnt   <= '0;
            acc   <= {{XLEN{1'b0}}, a};
            opb   <= b;
        end else if (busy) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU with iterative RV M-extension.
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   flush_i - abandon any in-flight op; no result is produced for it
//   bus     - alu_mdu_if.slave: valid_i/ready_o request, alu_op/rs1/rs2,
//             valid_o one-cycle result pulse, rd held result
// Single-cycle ops (and division special cases) answer one cycle after
// accept; MUL*/DIV*/REM* run XLEN iterations in mdu_iter on magnitudes
// and are sign-corrected when the last iteration completes.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    alu_mdu_if.slave   bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e state_q, state_d;

    alu_op_e         op;
    logic [XLEN-1:0] a, b;
    logic [SHW-1:0]  shamt;

    assign op    = alu_op_e'(bus.alu_op);
    assign a     = bus.rs1;
    assign b     = bus.rs2;
    assign shamt = b[SHW-1:0];

    // Division special cases bypass the iterator.
    logic div_zero, div_ovf, div_special;
    assign div_zero    = (b == '0);
    assign div_ovf     = (a == MIN_NEG) && (b == '1);
    assign div_special = is_div_op(op) &&
                         (div_zero || (div_ovf && (op == ALU_DIV || op == ALU_REM)));

    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_SLL:  alu_res = a << shamt;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $signed(a) >>> shamt;
            ALU_PASS: alu_res = b;
            ALU_DIV:  alu_res = div_zero ? '1 : a;
            ALU_DIVU: alu_res = '1;
            ALU_REM:  alu_res = div_zero ? a : '0;
            ALU_REMU: alu_res = a;
            default:  alu_res = '0;
        endcase
    end

    // Operand magnitudes and sign flags for the iterative path.
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    always_comb begin
        a_neg = a[XLEN-1] && (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        b_neg = b[XLEN-1] && (op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    logic ready, accept, start_iter, finish;
    logic iter_done;
    logic [2*XLEN-1:0] iter_res;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ready      = (state_q == IDLE);
        accept     = 1'b0;
        start_iter = 1'b0;
        finish     = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        accept = 1'b1;
                        if (is_mul_op(op)) begin
                            start_iter = 1'b1;
                            state_d    = MUL;
                        end else if (is_div_op(op) && !div_special) begin
                            start_iter = 1'b1;
                            state_d    = DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    if (iter_done) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_iter),
        .abort  (flush_i),
        .is_div (is_div_op(op)),
        .a      (a_mag),
        .b      (b_mag),
        .done   (iter_done),
        .result (iter_res)
    );

    alu_op_e op_q;
    logic    neg_lo_q;   // product / quotient negative
    logic    neg_hi_q;   // remainder negative (follows dividend)

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, mdu_res;
    always_comb begin
        prod    = neg_lo_q ? -iter_res : iter_res;
        quot    = iter_res[XLEN-1:0];
        rem     = iter_res[2*XLEN-1:XLEN];
        quot    = neg_lo_q ? -quot : quot;
        rem     = neg_hi_q ? -rem : rem;
        mdu_res = '0;
        case (op_q)
            ALU_MUL:                          mdu_res = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  mdu_res = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                mdu_res = quot;
            ALU_REM, ALU_REMU:                mdu_res = rem;
            default:                          mdu_res = '0;
        endcase
    end

    logic [XLEN-1:0] rd_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '0;
            valid_q  <= 1'b0;
            op_q     <= ALU_ADD;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept && !start_iter) begin
                rd_q    <= alu_res;
                valid_q <= 1'b1;
            end
            if (start_iter) begin
                op_q     <= op;
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= a_neg;
            end
            if (finish) begin
                rd_q    <= mdu_res;
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.rd      = rd_q;
endmodule
